// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers with glitch-free ratio updates,
// per-channel end-of-period ticks and a global phase resync.
module clock_divider_bank #(
   parameter int CHANNELS = 4,
   parameter int DIV_W    = 8,
   parameter int DEF_DIV  = 2,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] enable,
   input  logic                resync,
   input  logic                cfg_valid,
   input  logic [CH_W-1:0]     cfg_chan,
   input  logic [DIV_W-1:0]    cfg_div,
   output logic                cfg_ready,
   output logic [CHANNELS-1:0] cfg_pending,
   output logic [CHANNELS-1:0] clock_out,
   output logic [CHANNELS-1:0] tick
);

   logic [CHANNELS-1:0] pend_vec;
   logic [CHANNELS-1:0] out_vec;
   logic [CHANNELS-1:0] tick_vec;
   logic [DIV_W-1:0]    cfg_div_clamped;
   logic                accept;

   // Out-of-range channel numbers match no channel, so they stay ready and are dropped.
   always_comb begin
      cfg_ready = 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
         if (cfg_chan == CH_W'(c)) begin
            cfg_ready = ~pend_vec[c];
         end
      end
      accept          = cfg_valid & cfg_ready;
      cfg_div_clamped = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
   end

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         logic [DIV_W-1:0] cnt_reg, div_reg, pend_div_reg;
         logic [DIV_W-1:0] cnt_next, div_next, half_next;
         logic             pend_reg, out_reg, tick_reg;
         logic             wrap, hold, apply, sel;

         always_comb begin
            wrap      = (cnt_reg == div_reg - DIV_W'(1));
            hold      = resync | ~enable[gi];
            apply     = pend_reg & (hold | wrap);
            sel       = accept & (cfg_chan == CH_W'(gi));
            div_next  = apply ? pend_div_reg : div_reg;
            half_next = div_next - (div_next >> 1);
            cnt_next  = (hold | wrap) ? '0 : cnt_reg + DIV_W'(1);
         end

         // Outputs are derived from the next count so they line up with cnt_reg.
         always_ff @(posedge clock) begin
            if (reset) begin
               cnt_reg      <= '0;
               div_reg      <= DIV_W'(DEF_DIV);
               pend_div_reg <= DIV_W'(DEF_DIV);
               pend_reg     <= 1'b0;
               out_reg      <= 1'b0;
               tick_reg     <= 1'b0;
            end else begin
               cnt_reg <= cnt_next;
               div_reg <= div_next;
               if (hold) begin
                  out_reg  <= 1'b0;
                  tick_reg <= 1'b0;
               end else begin
                  out_reg  <= (cnt_next >= half_next);
                  tick_reg <= (cnt_next == div_next - DIV_W'(1));
               end
               // sel needs pend clear and apply needs pend set, so they never collide.
               if (sel) begin
                  pend_reg     <= 1'b1;
                  pend_div_reg <= cfg_div_clamped;
               end else if (apply) begin
                  pend_reg <= 1'b0;
               end
            end
         end

         assign pend_vec[gi] = pend_reg;
         assign out_vec[gi]  = out_reg;
         assign tick_vec[gi] = tick_reg;
      end
   endgenerate

   assign cfg_pending = pend_vec;
   assign clock_out   = out_vec;
   assign tick        = tick_vec;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank with a per-cycle reference model feeding
// an expected-value queue, plus targeted period/latency/handshake checks.
module tb_clock_divider_bank;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       resync = 1'b0;
   logic [3:0] enable = 4'h0;
   logic       cfg_valid = 1'b0;
   logic [1:0] cfg_chan = 2'd0;
   logic [7:0] cfg_div = 8'd0;
   logic       cfg_ready;
   logic [3:0] cfg_pending, clock_out, tick;

   // Three-channel instance so that an out-of-range channel number is representable.
   logic [2:0] b_enable = 3'h0;
   logic       b_cfg_valid = 1'b0;
   logic [1:0] b_cfg_chan = 2'd0;
   logic [7:0] b_cfg_div = 8'd0;
   logic       b_cfg_ready;
   logic [2:0] b_cfg_pending, b_clock_out, b_tick;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   clock_divider_bank #(.CHANNELS(4), .DIV_W(8), .DEF_DIV(2)) dut (
      .clock(clock), .reset(reset), .enable(enable), .resync(resync),
      .cfg_valid(cfg_valid), .cfg_chan(cfg_chan), .cfg_div(cfg_div),
      .cfg_ready(cfg_ready), .cfg_pending(cfg_pending),
      .clock_out(clock_out), .tick(tick)
   );

   clock_divider_bank #(.CHANNELS(3), .DIV_W(8), .DEF_DIV(2)) dut_b (
      .clock(clock), .reset(reset), .enable(b_enable), .resync(resync),
      .cfg_valid(b_cfg_valid), .cfg_chan(b_cfg_chan), .cfg_div(b_cfg_div),
      .cfg_ready(b_cfg_ready), .cfg_pending(b_cfg_pending),
      .clock_out(b_clock_out), .tick(b_tick)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference model: updated on each rising edge from the inputs the DUT samples.
   typedef struct packed {
      logic [3:0] out;
      logic [3:0] tck;
      logic [3:0] pend;
   } exp_t;
   exp_t exp_q[$];
   int   m_cnt[4], m_div[4], m_pdiv[4];
   logic [3:0] m_pend = 4'h0, m_out = 4'h0, m_tick = 4'h0;

   initial begin
      logic take, at_end;
      forever begin
         @(posedge clock);
         for (int c = 0; c < 4; c++) begin
            if (reset) begin
               m_cnt[c] = 0; m_div[c] = 2; m_pdiv[c] = 2;
               m_pend[c] = 1'b0; m_out[c] = 1'b0; m_tick[c] = 1'b0;
            end else begin
               take   = cfg_valid && (cfg_chan == c) && !m_pend[c];
               at_end = (m_cnt[c] == m_div[c] - 1);
               if (m_pend[c] && (resync || !enable[c] || at_end)) begin
                  m_div[c]  = m_pdiv[c];
                  m_pend[c] = 1'b0;
               end
               if (resync || !enable[c]) begin
                  m_cnt[c] = 0; m_out[c] = 1'b0; m_tick[c] = 1'b0;
               end else begin
                  m_cnt[c]  = at_end ? 0 : m_cnt[c] + 1;
                  m_out[c]  = (m_cnt[c] >= m_div[c] - m_div[c] / 2);
                  m_tick[c] = (m_cnt[c] == m_div[c] - 1);
               end
               if (take) begin
                  m_pdiv[c] = (cfg_div < 8'd2) ? 2 : int'(cfg_div);
                  m_pend[c] = 1'b1;
               end
            end
         end
         exp_q.push_back({m_out, m_tick, m_pend});
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk("model_clock_out", clock_out, e.out);
            chk("model_tick", tick, e.tck);
            chk("model_pending", cfg_pending, e.pend);
         end
         chk("model_cfg_ready", cfg_ready, !m_pend[cfg_chan]);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic write(input int ch, input int d);
      int n;
      cfg_valid = 1'b1;
      cfg_chan  = 2'(ch);
      cfg_div   = 8'(d);
      #1;
      n = 0;
      while (!cfg_ready && n < 64) begin
         step();
         n++;
      end
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_apply(input int ch, output int n);
      n = 0;
      while (cfg_pending[ch] && n < 64) begin
         step();
         n++;
      end
   endtask

   // Counts one full period of a channel, starting at a sample where it has just risen.
   task automatic measure(input int ch, output int period, output int highs, output int ticks);
      int   n;
      logic prev;
      n = 0; period = 0; highs = 0; ticks = 0;
      do begin
         prev = clock_out[ch];
         step();
         n++;
      end while (!(!prev && clock_out[ch]) && n < 64);
      do begin
         period++;
         highs += int'(clock_out[ch]);
         ticks += int'(tick[ch]);
         prev = clock_out[ch];
         step();
      end while (!(!prev && clock_out[ch]) && period < 64);
   endtask

   initial begin
      int         n, p, h, t;
      logic [2:0] b_prev, b_exp;
      logic [3:0] snap[24];
      logic [3:0] prev4;
      int         rises[4];
      int         exp_rises[4];

      exp_rises[0] = 8; exp_rises[1] = 6; exp_rises[2] = 4; exp_rises[3] = 3;

      repeat (3) step();
      chk("reset_clock_out", clock_out, 4'h0);
      chk("reset_tick", tick, 4'h0);
      chk("reset_pending", cfg_pending, 4'h0);
      chk("reset_cfg_ready", cfg_ready, 1'b1);

      // Released right after a reset edge: that edge plus one more gives the first rise.
      reset = 1'b0;
      enable = 4'hF;
      b_enable = 3'h7;
      step();
      chk("def_first_rise", clock_out, 4'hF);
      chk("def_first_tick", tick, 4'hF);
      step();
      chk("def_first_fall", clock_out, 4'h0);
      chk("def_tick_low", tick, 4'h0);
      repeat (4) step();

      write(1, 5);
      chk("ch1_pending_set", cfg_pending[1], 1'b1);
      wait_apply(1, n);
      chk("ch1_pending_clear", cfg_pending[1], 1'b0);
      measure(1, p, h, t);
      chk("ch1_period", p, 5);
      chk("ch1_high_cycles", h, 2);
      chk("ch1_low_cycles", p - h, 3);
      chk("ch1_ticks", t, 1);

      cfg_valid = 1'b1;
      cfg_chan  = 2'd2;
      cfg_div   = 8'd7;
      #1;
      chk("ch2_ready_first", cfg_ready, 1'b1);
      step();
      cfg_div = 8'd3;
      chk("ch2_stall", cfg_ready, 1'b0);
      chk("ch2_pending_first", cfg_pending[2], 1'b1);
      n = 0;
      while (!cfg_ready && n < 64) begin
         step();
         n++;
      end
      step();
      cfg_valid = 1'b0;
      chk("ch2_pending_second", cfg_pending[2], 1'b1);
      // Second write lands one cycle into a period of 7, so it applies 6 edges later.
      wait_apply(2, n);
      chk("ch2_second_apply_delay", n, 6);
      measure(2, p, h, t);
      chk("ch2_period", p, 3);
      chk("ch2_high_cycles", h, 1);

      write(3, 4);
      wait_apply(3, n);
      measure(3, p, h, t);
      chk("ch3_period4", p, 4);
      write(3, 0);
      wait_apply(3, n);
      measure(3, p, h, t);
      chk("ch3_div0_period", p, 2);
      write(3, 1);
      wait_apply(3, n);
      measure(3, p, h, t);
      chk("ch3_div1_period", p, 2);
      chk("ch3_div1_ticks", t, 1);

      b_cfg_valid = 1'b1;
      b_cfg_chan  = 2'd3;
      b_cfg_div   = 8'd9;
      #1;
      chk("oor_cfg_ready", b_cfg_ready, 1'b1);
      step();
      b_cfg_valid = 1'b0;
      chk("oor_pending", b_cfg_pending, 3'h0);
      b_prev = b_clock_out;
      for (int i = 0; i < 4; i++) begin
         step();
         b_exp = ~b_prev;
         chk("oor_toggle", b_clock_out, b_exp);
         b_prev = b_clock_out;
      end

      write(0, 3);
      write(1, 4);
      write(2, 6);
      write(3, 8);
      n = 0;
      while (cfg_pending != 4'h0 && n < 64) begin
         step();
         n++;
      end
      chk("mix_all_applied", cfg_pending, 4'h0);
      resync = 1'b1;
      step();
      resync = 1'b0;
      chk("resync_clock_out", clock_out, 4'h0);
      chk("resync_tick", tick, 4'h0);
      for (int c = 0; c < 4; c++) rises[c] = 0;
      for (int i = 0; i < 24; i++) begin
         snap[i] = clock_out;
         prev4 = clock_out;
         step();
         for (int c = 0; c < 4; c++) rises[c] += int'(!prev4[c] && clock_out[c]);
      end
      for (int c = 0; c < 4; c++) chk("resync_rises_per_24", rises[c], exp_rises[c]);
      for (int i = 0; i < 24; i++) begin
         chk("resync_repeat_24", clock_out, snap[i]);
         step();
      end

      // Counting the last disabled edge, a D=3 channel rises ceil(3/2)+1 = 3 edges later.
      enable[0] = 1'b0;
      repeat (3) step();
      chk("dis_clock_out", clock_out[0], 1'b0);
      chk("dis_tick", tick[0], 1'b0);
      enable[0] = 1'b1;
      step();
      chk("reen_still_low", clock_out[0], 1'b0);
      step();
      chk("reen_first_rise", clock_out[0], 1'b1);

      reset     = 1'b1;
      cfg_valid = 1'b1;
      cfg_chan  = 2'd3;
      cfg_div   = 8'd9;
      step();
      cfg_valid = 1'b0;
      chk("midreset_clock_out", clock_out, 4'h0);
      chk("midreset_tick", tick, 4'h0);
      chk("midreset_pending", cfg_pending, 4'h0);
      reset = 1'b0;
      step();
      chk("postreset_def_rise", clock_out, 4'hF);
      step();
      chk("postreset_def_fall", clock_out, 4'h0);
      measure(3, p, h, t);
      chk("postreset_period", p, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Multi-channel programmable clock divider for the transmitter datapath, succeeding the fixed /2, /4, /8 generator. It produces CHANNELS independent divided clocks from the single system clock, each with its own run-time divide ratio. Ratio changes take effect without glitches through a valid/ready configuration port. Each channel also outputs an end-of-period tick strobe, and a global resync aligns all channel phases. Symbol-rate, bit-rate and sample-rate enables for downstream transmitter stages are taken from its outputs.

## Interface
- CHANNELS, 4: number of independent divider channels (1..16)
- DIV_W, 8: width of each divide-ratio register
- DEF_DIV, 2: divide ratio loaded into every channel at reset (2..2^DIV_W-1)
- CH_W, $clog2(CHANNELS) (minimum 1): width of the channel select
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  CHANNELS  per-channel run enable
- resync  input  1  one-cycle pulse; restarts all channels at phase 0
- cfg_valid  input  1  configuration write request
- cfg_chan  input  CH_W  target channel of the write
- cfg_div  input  DIV_W  new divide ratio
- cfg_ready  output  1  write accepted this cycle when high together with cfg_valid
- cfg_pending  output  CHANNELS  per-channel flag: a new ratio is waiting to apply
- clock_out  output  CHANNELS  divided clocks, registered
- tick  output  CHANNELS  high during the last cycle of each period, registered

## Operation
- Per-channel state: cnt[DIV_W], div[DIV_W], pend_div[DIV_W], pend flag, out register, tick register.
- Effective ratio D = div. H = D - floor(D/2).
- Running channel (enable=1), each cycle:
  - Wrap: cnt_next = 0 if cnt == D-1, else cnt+1.
  - Ratio apply at wrap: if pend is set and cnt == D-1, then div <= pend_div, pend <= 0, and D_next = pend_div. Otherwise D_next = D.
  - Registered outputs: out <= (cnt_next >= H_next) and tick <= (cnt_next == D_next-1).
- Waveform: low for ceil(D/2) cycles, then high for floor(D/2) cycles. The period is exactly D cycles, and rising edges are one per period.
- Disabled channel (enable=0):
  - cnt, out and tick are forced to 0 on the next edge.
  - A pending ratio applies on that same edge.
  - On re-enable, the channel starts at cnt=0, so the output is low first.
- resync=1 sets cnt=0, out=0 and tick=0 on all channels on the next edge. Pending ratios apply on that edge. resync overrides the wrap logic.
- Configuration handshake:
  - cfg_ready = ~pend[cfg_chan], combinational. If cfg_chan >= CHANNELS, cfg_ready = 1.
  - Accept condition: cfg_valid & cfg_ready. On accept, pend_div[cfg_chan] <= max(cfg_div, 2) and pend <= 1.
  - If cfg_chan >= CHANNELS, the accept completes and the data is discarded.
  - An accepted write never applies in its own acceptance cycle. It applies at the first wrap, disable or resync edge strictly after acceptance.
  - While pend is set, further writes to that channel stall until the apply edge clears pend. cfg_ready rises the following cycle.
- cfg_pending = pend flags.
- Ratio arithmetic is unsigned DIV_W-bit. cfg_div values of 0 or 1 are clamped to 2, and no bypass mode exists.

## Timing
- Reset values:
  - cnt=0, div=DEF_DIV, pend=0, pend_div=DEF_DIV.
  - clock_out=0, tick=0, cfg_pending=0.
  - cfg_ready=1.
- reset overrides resync, enable and configuration in the same cycle. A write presented during reset is not accepted.
- Latency:
  - enable rising to first clock_out rise: ceil(D/2)+1 edges.
  - resync to realigned phase: 1 edge.
  - Accept to pending flag set: 1 edge.
- Simultaneous events:
  - An accept in the same cycle as a wrap on that channel defers the apply to the following wrap.
  - resync and an accept in the same cycle: the accept sets pend, and the resync edge applies only previously pending values.
- Glitch-free: clock_out changes only on rising edges of clock. Its high and low intervals are never shorter than floor(min(D_old,D_new)/2) cycles across a ratio change.

## Test plan
- Reset, then all enables at 1 with DEF_DIV=2. Required: clock_out toggles every cycle, first rise 2 edges after reset release, and tick is high on every high phase.
- Channel 1, write div=5 while running at 2. Required: cfg_pending[1]=1 until the next wrap, then a period of 5 with 3 low and 2 high cycles, and tick once per 5 cycles.
- Back-to-back writes to channel 2 (div=7, then div=3). Required: cfg_ready low after the first accept until the wrap; the second write applies one wrap later.
- Write cfg_div=0, then 1. Required: the channel runs at period 2.
- cfg_chan=CHANNELS. Required: cfg_ready=1, the write is accepted, and no channel state changes.
- Channels running with div 3, 4, 6, 8, then a resync pulse. Required: next cycle all cnt=0 and all outputs low, and rising edges coincide every 24 cycles thereafter. Also toggle enable[0] low for 3 cycles, then high, and check the first rise ceil(D/2)+1 edges later. Finally assert reset mid-period and check that all outputs are 0 and div returns to DEF_DIV.
